// File: rtl/iencoder_pkg.sv
// Shared RV32I encoder definitions: field widths, decoded type/funct codes,
// opcodes and funct3/funct7 constants common to the encoder and decoder.
package iencoder_pkg;

    localparam int unsigned INST_TYPE_WIDTH = 4;
    localparam int unsigned FUNCT_WIDTH     = 4;
    localparam int unsigned IMM_WIDTH       = 32;
    localparam int unsigned REG_WIDTH       = 5;
    localparam int unsigned INST_WIDTH      = 32;

    typedef enum logic [INST_TYPE_WIDTH-1:0] {
        INST_TYPE_IMM     = 4'd0,
        INST_TYPE_AUIPC   = 4'd1,
        INST_TYPE_JAL     = 4'd2,
        INST_TYPE_INT_IMM = 4'd3,
        INST_TYPE_INT_REG = 4'd4,
        INST_TYPE_BRANCH  = 4'd5,
        INST_TYPE_STORE   = 4'd6
    } inst_type_t;

    typedef enum logic [FUNCT_WIDTH-1:0] {
        FUNCT_ADD   = 4'd1,
        FUNCT_SUB   = 4'd2,
        FUNCT_AND   = 4'd3,
        FUNCT_EQ    = 4'd4,
        FUNCT_NEQ   = 4'd5,
        FUNCT_LT    = 4'd6,
        FUNCT_GTE   = 4'd7,
        FUNCT_LTU   = 4'd8,
        FUNCT_GTEU  = 4'd9,
        FUNCT_BYTE  = 4'd10,
        FUNCT_HWORD = 4'd11,
        FUNCT_WORD  = 4'd12
    } funct_t;

    localparam logic [6:0] OPCODE_LUI     = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL     = 7'b1101111;
    localparam logic [6:0] OPCODE_INT_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_INT_REG = 7'b0110011;
    localparam logic [6:0] OPCODE_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPCODE_STORE   = 7'b0100011;

    localparam logic [2:0] FUNCT3_ADD   = 3'd0;
    localparam logic [2:0] FUNCT3_AND   = 3'd7;
    localparam logic [2:0] FUNCT3_BEQ   = 3'd0;
    localparam logic [2:0] FUNCT3_BNE   = 3'd1;
    localparam logic [2:0] FUNCT3_BLT   = 3'd4;
    localparam logic [2:0] FUNCT3_BGE   = 3'd5;
    localparam logic [2:0] FUNCT3_BLTU  = 3'd6;
    localparam logic [2:0] FUNCT3_BGEU  = 3'd7;
    localparam logic [2:0] FUNCT3_BYTE  = 3'd0;
    localparam logic [2:0] FUNCT3_HWORD = 3'd1;
    localparam logic [2:0] FUNCT3_WORD  = 3'd2;

    localparam logic [6:0] FUNCT7_ADD = 7'b0000000;
    localparam logic [6:0] FUNCT7_SUB = 7'b0100000;

    localparam logic [INST_WIDTH-1:0] INST_NOP = 32'h00000013;

endpackage

// File: rtl/iencoder_fifo.sv
// Two-entry synchronous FIFO; slot0 is always the head, slot1 the tail.
module iencoder_fifo #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] dout
);

    logic [1:0]       count;
    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;
    logic             do_push;
    logic             do_pop;

    assign ready   = (count != 2'd2);
    assign valid   = (count != 2'd0);
    assign dout    = slot0;
    assign do_push = push && ready;
    assign do_pop  = pop && valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            // With a pop the tail shifts forward; the new entry lands behind whatever remains.
            if (do_pop) begin
                slot0 <= slot1;
                if (do_push) begin
                    if (count == 2'd1) slot0 <= din;
                    else               slot1 <= din;
                end
            end else if (do_push) begin
                if (count == 2'd0) slot0 <= din;
                else               slot1 <= din;
            end
            if (do_push && !do_pop)      count <= count + 2'd1;
            else if (do_pop && !do_push) count <= count - 2'd1;
        end
    end

endmodule

// File: rtl/iencoder.sv
// RV32I instruction encoder feeding a 2-entry output queue.
// Optional macro IENCODER_RANGE_CHECK_EN flags immediates that do not fit their field.
module iencoder
    import iencoder_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INST_TYPE_WIDTH-1:0] inst_type,
    input  logic [FUNCT_WIDTH-1:0]     funct,
    input  logic [IMM_WIDTH-1:0]       imm,
    input  logic [REG_WIDTH-1:0]       rd,
    input  logic [REG_WIDTH-1:0]       rs1,
    input  logic [REG_WIDTH-1:0]       rs2,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INST_WIDTH-1:0]      inst,
    output logic                       inst_err,
    output logic [7:0]                 err_count
);

    logic [INST_WIDTH-1:0] word;
    logic                  bad;
    logic                  enc_err;
    logic [2:0]            f3;
    logic                  push;

    always_comb begin
        word = '0;
        bad  = 1'b0;
        f3   = '0;
        case (inst_type)
            INST_TYPE_IMM:   word = {imm[31:12], rd, OPCODE_LUI};
            INST_TYPE_AUIPC: word = {imm[31:12], rd, OPCODE_AUIPC};
            INST_TYPE_JAL:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPCODE_JAL};
            INST_TYPE_INT_IMM: begin
                case (funct)
                    FUNCT_ADD: f3 = FUNCT3_ADD;
                    FUNCT_AND: f3 = FUNCT3_AND;
                    default:   bad = 1'b1;
                endcase
                word = {imm[11:0], rs1, f3, rd, OPCODE_INT_IMM};
            end
            INST_TYPE_INT_REG: begin
                case (funct)
                    FUNCT_ADD: word = {FUNCT7_ADD, rs2, rs1, FUNCT3_ADD, rd, OPCODE_INT_REG};
                    FUNCT_SUB: word = {FUNCT7_SUB, rs2, rs1, FUNCT3_ADD, rd, OPCODE_INT_REG};
                    FUNCT_AND: word = {FUNCT7_ADD, rs2, rs1, FUNCT3_AND, rd, OPCODE_INT_REG};
                    default:   bad = 1'b1;
                endcase
            end
            INST_TYPE_BRANCH: begin
                case (funct)
                    FUNCT_EQ:   f3 = FUNCT3_BEQ;
                    FUNCT_NEQ:  f3 = FUNCT3_BNE;
                    FUNCT_LT:   f3 = FUNCT3_BLT;
                    FUNCT_GTE:  f3 = FUNCT3_BGE;
                    FUNCT_LTU:  f3 = FUNCT3_BLTU;
                    FUNCT_GTEU: f3 = FUNCT3_BGEU;
                    default:    bad = 1'b1;
                endcase
                word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPCODE_BRANCH};
            end
            INST_TYPE_STORE: begin
                case (funct)
                    FUNCT_BYTE:  f3 = FUNCT3_BYTE;
                    FUNCT_HWORD: f3 = FUNCT3_HWORD;
                    FUNCT_WORD:  f3 = FUNCT3_WORD;
                    default:     bad = 1'b1;
                endcase
                word = {imm[11:5], rs2, rs1, f3, imm[4:0], OPCODE_STORE};
            end
            default: bad = 1'b1;
        endcase
        if (bad) word = INST_NOP;
    end

`ifdef IENCODER_RANGE_CHECK_EN
    logic range_bad;

    // An immediate fits when every bit above its top field bit copies that bit.
    always_comb begin
        range_bad = 1'b0;
        case (inst_type)
            INST_TYPE_IMM, INST_TYPE_AUIPC:
                range_bad = (imm[11:0] != '0);
            INST_TYPE_JAL:
                range_bad = (imm[31:20] != {12{imm[20]}}) || imm[0];
            INST_TYPE_INT_IMM, INST_TYPE_STORE:
                range_bad = (imm[31:11] != {21{imm[11]}});
            INST_TYPE_BRANCH:
                range_bad = (imm[31:12] != {20{imm[12]}}) || imm[0];
            default:
                range_bad = 1'b0;
        endcase
    end

    assign enc_err = bad || range_bad;
`else
    assign enc_err = bad;
`endif

    assign push = in_valid && in_ready;

    iencoder_fifo #(
        .WIDTH(INST_WIDTH + 1)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (in_valid),
        .din  ({word, enc_err}),
        .ready(in_ready),
        .pop  (out_ready),
        .valid(out_valid),
        .dout ({inst, inst_err})
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_count <= '0;
        end else if (push && enc_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule
